// File: rtl/aim_pkg.sv
// Shared constants, weight codes, FSM states and buffer entry layout for the
// AIM sparse activation encoder.
package aim_pkg;

   localparam int N  = 8;
   localparam int AW = 9;
   localparam int WW = 2;
   localparam int PW = $clog2(N);
   localparam int CW = $clog2(N + 1);

   localparam logic [WW-1:0] W_NEG  = 2'b11;
   localparam logic [WW-1:0] W_ZERO = 2'b00;
   localparam logic [WW-1:0] W_POS  = 2'b01;
   localparam logic [WW-1:0] W_ILL  = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      EMIT = 2'd2,
      DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic [AW-1:0] data;
      logic [PW-1:0] pos;
      logic [WW-1:0] w;
   } entry_t;

   // The illegal code counts as a zero weight in the bitmap.
   function automatic logic is_nz_weight(input logic [WW-1:0] w);
      return (w == W_POS) || (w == W_NEG);
   endfunction

endpackage

// File: rtl/aim_sparse_encoder_if.sv
// Compressed-activation stream: one nonzero activation per beat, tagged with
// its original position and weight.
interface aim_sparse_encoder_if;
   import aim_pkg::*;

   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] out_data;
   logic [PW-1:0] out_pos;
   logic [WW-1:0] out_w;
   logic          out_last;

   modport master (
      output out_valid, out_data, out_pos, out_w, out_last,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_data, out_pos, out_w, out_last,
      output out_ready
   );

endinterface

// File: rtl/aim_sparse_buf.sv
// Packed buffer of nonzero activations in ascending original index, filled
// during the scan and drained by the stream handshake.
module aim_sparse_buf
   import aim_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          wr_en,
   input  entry_t        wr_entry,
   input  logic          rd_adv,
   output entry_t        rd_entry,
   output logic [CW-1:0] rd_ptr
);

   entry_t        mem [N];
   logic [CW-1:0] wr_ptr;

   // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en)  wr_ptr <= wr_ptr + CW'(1);
         if (rd_adv) rd_ptr <= rd_ptr + CW'(1);
      end
   end

   // NOTE: storage has no reset; entries are only read below the write pointer.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr[PW-1:0]] <= wr_entry;
   end

   assign rd_entry = mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/aim_sparse_encoder.sv
// Sparse activation encoder: scans one frame per element per cycle, builds
// activation/weight bitmaps, then streams the nonzero activations.
module aim_sparse_encoder
   import aim_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N*AW-1:0]      act_in,
   input  logic [N*WW-1:0]      w_in,
   output logic [N-1:0]         act_bitmap,
   output logic [N-1:0]         wgt_bitmap,
   output logic [CW-1:0]        nz_count,
   output logic                 bm_valid,
   output logic                 w_err,
   output logic                 frame_done,
   aim_sparse_encoder_if.master stream
);

   state_t        state, state_nxt;
   logic          alive;
   logic [N*AW-1:0] act_q;
   logic [N*WW-1:0] w_q;
   logic [PW-1:0] idx;
   logic          accept;
   logic          scanning;
   logic          last_idx;
   logic          fire;
   logic [AW-1:0] cur_act;
   logic [WW-1:0] cur_w;
   logic          cur_nz;
   logic [CW-1:0] count_nxt;
   logic [CW-1:0] rd_ptr;
   entry_t        wr_entry;
   entry_t        rd_entry;

   // alive holds in_ready low while in reset and releases it one edge later.
   assign in_ready  = alive && (state == IDLE);
   assign accept    = in_valid && in_ready;
   assign scanning  = (state == SCAN);
   assign last_idx  = (idx == PW'(N - 1));
   assign cur_act   = act_q[idx*AW +: AW];
   assign cur_w     = w_q[idx*WW +: WW];
   assign cur_nz    = |cur_act;
   assign count_nxt = nz_count + CW'(cur_nz);
   assign fire      = stream.out_valid && stream.out_ready;

   assign wr_entry = '{data: cur_act, pos: idx, w: cur_w};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         alive <= 1'b0;
      end else begin
         state <= state_nxt;
         alive <= 1'b1;
      end
   end

   // NOTE: state_nxt gets a default before the case so no latch is inferred.
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (accept) state_nxt = SCAN;
         SCAN: if (last_idx) state_nxt = (count_nxt != '0) ? EMIT : DONE;
         EMIT: if (fire && stream.out_last) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_q      <= '0;
         w_q        <= '0;
         idx        <= '0;
         act_bitmap <= '0;
         wgt_bitmap <= '0;
         nz_count   <= '0;
         w_err      <= 1'b0;
         bm_valid   <= 1'b0;
      end else if (accept) begin
         act_q      <= act_in;
         w_q        <= w_in;
         idx        <= '0;
         act_bitmap <= '0;
         wgt_bitmap <= '0;
         nz_count   <= '0;
         w_err      <= 1'b0;
         bm_valid   <= 1'b0;
      end else if (scanning) begin
         act_bitmap[idx] <= cur_nz;
         wgt_bitmap[idx] <= is_nz_weight(cur_w);
         if (cur_w == W_ILL) w_err <= 1'b1;
         nz_count <= count_nxt;
         idx      <= last_idx ? '0 : idx + PW'(1);
         if (last_idx) bm_valid <= 1'b1;
      end
   end

   aim_sparse_buf u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (accept),
      .wr_en    (scanning && cur_nz),
      .wr_entry (wr_entry),
      .rd_adv   (fire),
      .rd_entry (rd_entry),
      .rd_ptr   (rd_ptr)
   );

   // Stream fields are forced to zero outside EMIT so reset clears them at once.
   always_comb begin
      stream.out_valid = (state == EMIT);
      stream.out_last  = stream.out_valid && (rd_ptr == nz_count - CW'(1));
      stream.out_data  = stream.out_valid ? rd_entry.data : '0;
      stream.out_pos   = stream.out_valid ? rd_entry.pos  : '0;
      stream.out_w     = stream.out_valid ? rd_entry.w    : '0;
   end

   assign frame_done = (state == DONE);

endmodule

// File: tb/tb_aim_sparse_encoder.sv
// Directed self-checking bench for aim_sparse_encoder: nominal frame, empty
// frame, backpressure, reset mid-stream, held in_valid and illegal weight.
module tb_aim_sparse_encoder;
   import aim_pkg::*;

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            in_valid;
   logic            in_ready;
   logic [N*AW-1:0] act_in;
   logic [N*WW-1:0] w_in;
   logic [N-1:0]    act_bitmap;
   logic [N-1:0]    wgt_bitmap;
   logic [CW-1:0]   nz_count;
   logic            bm_valid;
   logic            w_err;
   logic            frame_done;

   int passed = 0;
   int total  = 0;

   aim_sparse_encoder_if sif ();

   aim_sparse_encoder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .act_in     (act_in),
      .w_in       (w_in),
      .act_bitmap (act_bitmap),
      .wgt_bitmap (wgt_bitmap),
      .nz_count   (nz_count),
      .bm_valid   (bm_valid),
      .w_err      (w_err),
      .frame_done (frame_done),
      .stream     (sif.master)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [N*AW-1:0] pa(input int a0, a1, a2, a3, a4, a5, a6, a7);
      logic [N*AW-1:0] r;
      int v [N];
      v = '{a0, a1, a2, a3, a4, a5, a6, a7};
      for (int i = 0; i < N; i++) r[i*AW +: AW] = AW'(v[i]);
      return r;
   endfunction

   function automatic logic [N*WW-1:0] pw(input logic [WW-1:0] w0, w1, w2, w3, w4, w5, w6, w7);
      return {w7, w6, w5, w4, w3, w2, w1, w0};
   endfunction

   task automatic show(input string tag, input int d, input int p, input logic [WW-1:0] w,
                       input logic last);
      logic [AW-1:0] ed;
      logic [PW-1:0] ep;
      ed = AW'(d);
      ep = PW'(p);
      check({tag, "_valid"}, sif.out_valid, 1'b1);
      check({tag, "_data"},  sif.out_data,  ed);
      check({tag, "_pos"},   sif.out_pos,   ep);
      check({tag, "_w"},     sif.out_w,     w);
      check({tag, "_last"},  sif.out_last,  last);
   endtask

   task automatic beat(input string tag, input int d, input int p, input logic [WW-1:0] w,
                       input logic last);
      show(tag, d, p, w, last);
      cyc();
   endtask

   task automatic scan_quiet(input string tag);
      for (int i = 0; i < N; i++) begin
         check({tag, "_no_valid"}, sif.out_valid, 1'b0);
         check({tag, "_no_done"},  frame_done,    1'b0);
         cyc();
      end
   endtask

   logic [N*AW-1:0] act_a, act_b, act_c;
   logic [N*WW-1:0] w_a, w_b, w_c;

   initial begin
      act_a = pa(5, 0, -3, 0, 0, 7, 0, 1);
      w_a   = pw(W_POS, W_NEG, W_ZERO, W_POS, W_ZERO, W_NEG, W_POS, W_ZERO);
      act_b = pa(0, 0, 0, 4, 0, 0, 0, 0);
      w_b   = pw(W_ZERO, W_POS, W_ZERO, W_ILL, W_ZERO, W_ZERO, W_ZERO, W_ZERO);
      act_c = pa(-256, 0, 0, 0, 0, 0, 255, 0);
      w_c   = pw(W_ZERO, W_ZERO, W_ZERO, W_ZERO, W_ZERO, W_ZERO, W_NEG, W_ZERO);

      in_valid      = 1'b0;
      act_in        = '0;
      w_in          = '0;
      sif.out_ready = 1'b1;

      // Reset state
      #1 rst_n = 1'b0;
      #1;
      check("rst_in_ready",   in_ready,      1'b0);
      check("rst_out_valid",  sif.out_valid, 1'b0);
      check("rst_bm_valid",   bm_valid,      1'b0);
      check("rst_frame_done", frame_done,    1'b0);
      check("rst_act_bitmap", act_bitmap,    8'h00);
      check("rst_nz_count",   nz_count,      4'd0);
      cyc();
      check("rst_hold_in_ready", in_ready, 1'b0);
      rst_n = 1'b1;
      cyc();
      check("rel_in_ready", in_ready, 1'b1);

      // Nominal frame
      in_valid = 1'b1; act_in = act_a; w_in = w_a;
      check("t1_accept_ready", in_ready, 1'b1);
      cyc();
      in_valid = 1'b0;
      check("t1_scan_bm_valid", bm_valid, 1'b0);
      scan_quiet("t1_scan");
      check("t1_act_bitmap", act_bitmap, 8'b10100101);
      check("t1_wgt_bitmap", wgt_bitmap, 8'b01101011);
      check("t1_nz_count",   nz_count,   4'd4);
      check("t1_bm_valid",   bm_valid,   1'b1);
      check("t1_w_err",      w_err,      1'b0);
      beat("t1_b0", 5, 0, W_POS, 1'b0);
      beat("t1_b1", -3, 2, W_ZERO, 1'b0);
      beat("t1_b2", 7, 5, W_NEG, 1'b0);
      beat("t1_b3", 1, 7, W_ZERO, 1'b1);
      check("t1_frame_done",     frame_done,    1'b1);
      check("t1_done_no_valid",  sif.out_valid, 1'b0);
      check("t1_done_not_ready", in_ready,      1'b0);
      cyc();
      check("t1_done_pulse", frame_done, 1'b0);
      check("t1_idle_ready", in_ready,   1'b1);
      check("t1_bm_hold",    bm_valid,   1'b1);
      check("t1_act_hold",   act_bitmap, 8'b10100101);

      // All-zero activations
      in_valid = 1'b1; act_in = '0; w_in = {N{W_POS}};
      cyc();
      in_valid = 1'b0;
      scan_quiet("t2_scan");
      check("t2_frame_done", frame_done,    1'b1);
      check("t2_no_valid",   sif.out_valid, 1'b0);
      check("t2_nz_count",   nz_count,      4'd0);
      check("t2_act_bitmap", act_bitmap,    8'h00);
      check("t2_wgt_bitmap", wgt_bitmap,    8'hFF);
      check("t2_bm_valid",   bm_valid,      1'b1);
      cyc();
      check("t2_idle_ready", in_ready,   1'b1);
      check("t2_done_pulse", frame_done, 1'b0);

      // Backpressure on beat 2
      in_valid = 1'b1; act_in = act_a; w_in = w_a;
      cyc();
      in_valid = 1'b0;
      repeat (N) cyc();
      beat("t3_b0", 5, 0, W_POS, 1'b0);
      beat("t3_b1", -3, 2, W_ZERO, 1'b0);
      sif.out_ready = 1'b0;
      show("t3_stall0", 7, 5, W_NEG, 1'b0);
      cyc();
      show("t3_stall1", 7, 5, W_NEG, 1'b0);
      cyc();
      show("t3_stall2", 7, 5, W_NEG, 1'b0);
      cyc();
      sif.out_ready = 1'b1;
      beat("t3_b2", 7, 5, W_NEG, 1'b0);
      beat("t3_b3", 1, 7, W_ZERO, 1'b1);
      check("t3_frame_done", frame_done, 1'b1);
      cyc();
      check("t3_idle_ready", in_ready, 1'b1);

      // Reset during beat 1, then a fresh frame with extreme values
      in_valid = 1'b1; act_in = act_a; w_in = w_a;
      cyc();
      in_valid = 1'b0;
      repeat (N) cyc();
      beat("t4_b0", 5, 0, W_POS, 1'b0);
      show("t4_b1", -3, 2, W_ZERO, 1'b0);
      rst_n = 1'b0;
      #1;
      check("t4_rst_out_valid",  sif.out_valid, 1'b0);
      check("t4_rst_out_data",   sif.out_data,  9'd0);
      check("t4_rst_out_pos",    sif.out_pos,   3'd0);
      check("t4_rst_out_w",      sif.out_w,     2'd0);
      check("t4_rst_out_last",   sif.out_last,  1'b0);
      check("t4_rst_bm_valid",   bm_valid,      1'b0);
      check("t4_rst_act_bitmap", act_bitmap,    8'h00);
      check("t4_rst_wgt_bitmap", wgt_bitmap,    8'h00);
      check("t4_rst_nz_count",   nz_count,      4'd0);
      check("t4_rst_w_err",      w_err,         1'b0);
      check("t4_rst_frame_done", frame_done,    1'b0);
      check("t4_rst_in_ready",   in_ready,      1'b0);
      cyc();
      rst_n = 1'b1;
      cyc();
      check("t4_rel_ready",   in_ready,      1'b1);
      check("t4_rel_no_done", frame_done,    1'b0);
      check("t4_rel_no_valid", sif.out_valid, 1'b0);
      in_valid = 1'b1; act_in = act_c; w_in = w_c;
      cyc();
      in_valid = 1'b0;
      scan_quiet("t4_scan");
      check("t4_act_bitmap", act_bitmap, 8'b01000001);
      check("t4_wgt_bitmap", wgt_bitmap, 8'b01000000);
      check("t4_nz_count",   nz_count,   4'd2);
      check("t4_w_err",      w_err,      1'b0);
      beat("t4_c0", -256, 0, W_ZERO, 1'b0);
      beat("t4_c1", 255, 6, W_NEG, 1'b1);
      check("t4_frame_done", frame_done, 1'b1);
      cyc();
      check("t4_idle_ready", in_ready, 1'b1);

      // in_valid held across two frames; second frame carries an illegal weight
      in_valid = 1'b1; act_in = act_a; w_in = w_a;
      check("t5_accept_a", in_ready, 1'b1);
      cyc();
      act_in = act_b; w_in = w_b;
      for (int i = 0; i < N; i++) begin
         check("t5_scan_not_ready", in_ready, 1'b0);
         cyc();
      end
      beat("t5_a0", 5, 0, W_POS, 1'b0);
      beat("t5_a1", -3, 2, W_ZERO, 1'b0);
      beat("t5_a2", 7, 5, W_NEG, 1'b0);
      beat("t5_a3", 1, 7, W_ZERO, 1'b1);
      check("t5_a_done",      frame_done, 1'b1);
      check("t5_a_not_ready", in_ready,   1'b0);
      cyc();
      check("t5_accept_b", in_ready, 1'b1);
      cyc();
      in_valid = 1'b0;
      check("t5_b_bm_cleared",  bm_valid,   1'b0);
      check("t5_b_act_cleared", act_bitmap, 8'h00);
      check("t5_b_not_ready",   in_ready,   1'b0);
      repeat (N) cyc();
      check("t5_b_act_bitmap", act_bitmap, 8'b00001000);
      check("t5_b_wgt_bitmap", wgt_bitmap, 8'b00000010);
      check("t5_b_nz_count",   nz_count,   4'd1);
      check("t5_b_w_err",      w_err,      1'b1);
      check("t5_b_bm_valid",   bm_valid,   1'b1);
      beat("t5_b0", 4, 3, W_ILL, 1'b1);
      check("t5_b_done", frame_done, 1'b1);
      cyc();
      check("t5_b_idle",      in_ready, 1'b1);
      check("t5_b_err_hold",  w_err,    1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/aim_sparse_encoder.md
# aim_sparse_encoder

Sparse activation encoder for the AIM neuron datapath: accepts one frame of N signed activations plus N ternary weights, scans it one element per cycle, and emits the compressed format the AIM accumulator consumes. That format is an activation bitmap, a nonzero-weight bitmap, a nonzero count, and a packed stream of the nonzero activations tagged with original position. It sits between the activation producer and the AIM neuron (writer side of the compressed-activation interface).

## Interface
- N, 8, activations per frame
- AW, 9, activation width (signed)
- WW, 2, weight width (signed ternary: 2'b11=-1, 2'b00=0, 2'b01=+1)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  frame offered
- in_ready  out  1  frame accepted when in_valid && in_ready
- act_in  in  N*AW  activations, element i at [i*AW +: AW]
- w_in  in  N*WW  weights, element i at [i*WW +: WW]
- act_bitmap  out  N  bit i = (act i != 0)
- wgt_bitmap  out  N  bit i = (w i is +1 or -1)
- nz_count  out  $clog2(N+1)  popcount(act_bitmap)
- bm_valid  out  1  bitmaps/count valid
- w_err  out  1  frame contained illegal weight code 2'b10
- out_valid  out  1  stream beat valid
- out_ready  in  1  consumer ready
- out_data  out  AW  nonzero activation
- out_pos  out  $clog2(N)  original index
- out_w  out  WW  weight for that index
- out_last  out  1  final beat of frame
- frame_done  out  1  one-cycle pulse, frame complete

## Operation
- FSM states: IDLE, SCAN, EMIT, DONE.
- IDLE: in_ready=1. On accept, register act_in/w_in, clear bitmaps, count, write pointer, w_err, bm_valid; go to SCAN with scan index 0.
- SCAN: one element per cycle, index 0..N-1:
  - act_bitmap[i] set iff act != 0.
  - wgt_bitmap[i] set iff w is 2'b01 or 2'b11.
  - Code 2'b10 is treated as zero weight and sets w_err.
  - Nonzero activation: written into packed buffer at write pointer with pos i and w i; pointer and count increment.
  - After index N-1, go to EMIT if count>0, else DONE.
- EMIT: out_valid=1; beat k presents buffer entry k (ascending original index); out_last=1 on entry count-1. Advance only on out_valid && out_ready. Last handshake → DONE.
- DONE: frame_done=1 for one cycle; go to IDLE.
- bm_valid rises on entry to EMIT/DONE and holds, with bitmaps, nz_count and w_err stable, until the next accept.
- Activation value passes unmodified (no sign extension, no weighting); count max N, no overflow.
- in_valid outside IDLE is ignored; the producer must hold the frame.

## Timing
- Accept at cycle T; SCAN occupies T+1..T+N; first out_valid at T+N+1 (T+9 for N=8).
- nz_count=0: frame_done at T+N+1, in_ready at T+N+2.
- Last handshake at cycle X: frame_done at X+1, in_ready at X+2. Minimum frame period is N+2+nz_count cycles.
- Backpressure: out_data/out_pos/out_w/out_last held stable while out_valid && !out_ready; out_valid never drops mid-frame.
- Reset (any state, including mid-EMIT): state IDLE. Reset values: all outputs 0, in_ready 0 while rst_n low, 1 on the first cycle after release. The partial frame is discarded with no frame_done.

## Structure
- Shared package aim_pkg: N, AW, WW, weight codes (W_NEG, W_ZERO, W_POS, W_ILL), FSM state enum.
- Packed buffer (N entries of {data, pos, w}, write pointer, read pointer) as sub-module aim_sparse_buf. Top holds the FSM and bitmaps.

## Test plan
- Acts [5,0,-3,0,0,7,0,1], weights [+1,-1,0,+1,0,-1,+1,0] → act_bitmap 8'b10100101, wgt_bitmap 8'b01101011, nz_count 4. Beats (5,0,+1), (-3,2,0), (7,5,-1), (1,7,0,last). First beat at T+9, frame_done one cycle after last.
- All-zero activations → nz_count 0, out_valid never high, frame_done at T+9, act_bitmap 0.
- Same frame with out_ready low for 3 cycles on beat 2 → beat 2 fields stable 3 cycles, no duplicate or lost beats.
- rst_n pulsed low during beat 1 of EMIT → all outputs 0 immediately. New frame accepted after release gives a correct result.
- in_valid held high throughout with two different frames → second accepted only in IDLE after frame_done. Its bitmaps replace the first's.
- Weight 2'b10 at index 3 with act 4 → w_err=1, wgt_bitmap[3]=0, beat (4,3,2'b10) still emitted.
